// File: rtl/axi_rd_arb_pkg.sv
// Shared constants and types for the AXI read-channel arbiter.
package axi_rd_arb_pkg;

    localparam logic [3:0] ID_INST   = 4'd0;
    localparam logic [3:0] ID_DATA   = 4'd1;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK_NONE  = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

    function automatic logic [7:0] arlen_for(input logic [2:0] rd_type);
        return (rd_type == TYPE_LINE) ? 8'd3 : 8'd0;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI AR/R channel bundle; master side is driven by the arbiter.
interface axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/rd_outstanding_ctr.sv
// Per-ID in-flight transaction counter; saturates at MAX and never underflows.
module rd_outstanding_ctr #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic dec,
    output logic full
);
    localparam logic [2:0] LIMIT = 3'(MAX);

    logic [2:0] cnt;
    logic       inc_ok;
    logic       dec_ok;

    assign inc_ok = inc & (cnt < LIMIT);
    assign dec_ok = dec & (cnt != 3'd0);
    assign full   = (cnt >= LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= 3'd0;
        end else begin
            case ({inc_ok, dec_ok})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R pair between the icache and dcache read ports.
// Optional performance counters are built when AXI_RD_ARB_PERF_EN is defined.
//
// state | meaning
// IDLE  | arbitrate; winner gets addr_ok this cycle, request latched
// SEND  | arvalid held with latched address until arready
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic            inst_rd_req,
    input  logic [31:0]     inst_rd_addr,
    input  logic [2:0]      inst_rd_type,
    output logic            inst_rd_addr_ok,
    output logic            inst_rd_data_ok,
    output logic [31:0]     inst_rd_rdata,
    output logic            inst_rd_last,

    input  logic            data_rd_req,
    input  logic [31:0]     data_rd_addr,
    input  logic [2:0]      data_rd_type,
    output logic            data_rd_addr_ok,
    output logic            data_rd_data_ok,
    output logic [31:0]     data_rd_rdata,
    output logic            data_rd_last,

    axi_rd_arbiter_if.master axi
`ifdef AXI_RD_ARB_PERF_EN
   ,output logic [31:0]     perf_inst_grants,
    output logic [31:0]     perf_data_grants,
    output logic [31:0]     perf_ar_stall,
    output logic            perf_bad_rid
`endif
);
    localparam logic [3:0] STARVE_CMP = 4'(STARVE_LIMIT);

    arb_state_e  state;
    logic [3:0]  starve_cnt;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic [3:0]  arid_q;
    logic [7:0]  arlen_q;

    logic inst_full, data_full;
    logic inst_elig, data_elig;
    logic starved;
    logic grant_inst, grant_data;
    logic inst_match, data_match;
    logic unused_rresp;

    assign inst_elig  = inst_rd_req & ~inst_full;
    assign data_elig  = data_rd_req & ~data_full;
    assign starved    = (starve_cnt == STARVE_CMP);
    assign grant_inst = (state == IDLE) & inst_elig & (starved | ~data_elig);
    assign grant_data = (state == IDLE) & data_elig & ~grant_inst;

    assign inst_rd_addr_ok = grant_inst;
    assign data_rd_addr_ok = grant_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            arvalid_q  <= 1'b0;
            araddr_q   <= 32'd0;
            arid_q     <= 4'd0;
            arlen_q    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_inst || !inst_rd_req)
                        starve_cnt <= 4'd0;
                    else if (grant_data && starve_cnt != STARVE_CMP)
                        starve_cnt <= starve_cnt + 4'd1;

                    if (grant_data) begin
                        araddr_q  <= data_rd_addr;
                        arid_q    <= ID_DATA;
                        arlen_q   <= arlen_for(data_rd_type);
                        arvalid_q <= 1'b1;
                        state     <= SEND;
                    end else if (grant_inst) begin
                        araddr_q  <= inst_rd_addr;
                        arid_q    <= ID_INST;
                        arlen_q   <= arlen_for(inst_rd_type);
                        arvalid_q <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arid    = arid_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = AXI_LOCK_NONE;
    assign axi.arcache = AXI_CACHE_NONE;
    assign axi.arprot  = AXI_PROT_NONE;
    assign axi.rready  = 1'b1;

    // Beats carrying any other ID match neither port and are dropped.
    assign inst_match = axi.rvalid & (axi.rid == ID_INST);
    assign data_match = axi.rvalid & (axi.rid == ID_DATA);

    assign inst_rd_data_ok = inst_match;
    assign inst_rd_rdata   = inst_match ? axi.rdata : 32'd0;
    assign inst_rd_last    = inst_match & axi.rlast;
    assign data_rd_data_ok = data_match;
    assign data_rd_rdata   = data_match ? axi.rdata : 32'd0;
    assign data_rd_last    = data_match & axi.rlast;

    assign unused_rresp = ^axi.rresp;

    rd_outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_inst_ctr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (grant_inst),
        .dec    (inst_match & axi.rlast),
        .full   (inst_full)
    );

    rd_outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_data_ctr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (grant_data),
        .dec    (data_match & axi.rlast),
        .full   (data_full)
    );

`ifdef AXI_RD_ARB_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_inst_grants <= 32'd0;
            perf_data_grants <= 32'd0;
            perf_ar_stall    <= 32'd0;
            perf_bad_rid     <= 1'b0;
        end else begin
            if (grant_inst)
                perf_inst_grants <= perf_inst_grants + 32'd1;
            if (grant_data)
                perf_data_grants <= perf_data_grants + 32'd1;
            if (state == SEND && !axi.arready)
                perf_ar_stall <= perf_ar_stall + 32'd1;
            if (axi.rvalid && !(axi.rid == ID_INST || axi.rid == ID_DATA))
                perf_bad_rid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scenario bench for axi_rd_arbiter: expected AR and R traffic is queued when driven.
module tb_axi_rd_arbiter;
    import axi_rd_arb_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        inst_rd_req, data_rd_req;
    logic [31:0] inst_rd_addr, data_rd_addr;
    logic [2:0]  inst_rd_type, data_rd_type;
    logic        inst_rd_addr_ok, inst_rd_data_ok, inst_rd_last;
    logic        data_rd_addr_ok, data_rd_data_ok, data_rd_last;
    logic [31:0] inst_rd_rdata, data_rd_rdata;
`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0] perf_inst_grants, perf_data_grants, perf_ar_stall;
    logic        perf_bad_rid;
`endif

    axi_rd_arbiter_if axi();

    axi_rd_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(8)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_rd_req     (inst_rd_req),
        .inst_rd_addr    (inst_rd_addr),
        .inst_rd_type    (inst_rd_type),
        .inst_rd_addr_ok (inst_rd_addr_ok),
        .inst_rd_data_ok (inst_rd_data_ok),
        .inst_rd_rdata   (inst_rd_rdata),
        .inst_rd_last    (inst_rd_last),
        .data_rd_req     (data_rd_req),
        .data_rd_addr    (data_rd_addr),
        .data_rd_type    (data_rd_type),
        .data_rd_addr_ok (data_rd_addr_ok),
        .data_rd_data_ok (data_rd_data_ok),
        .data_rd_rdata   (data_rd_rdata),
        .data_rd_last    (data_rd_last),
        .axi             (axi)
`ifdef AXI_RD_ARB_PERF_EN
       ,.perf_inst_grants(perf_inst_grants),
        .perf_data_grants(perf_data_grants),
        .perf_ar_stall   (perf_ar_stall),
        .perf_bad_rid    (perf_bad_rid)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    ar_t   ar_q[$];
    beat_t r_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [3:0] id, input logic [31:0] data, input logic last);
        axi.rvalid = 1'b1;
        axi.rid    = id;
        axi.rdata  = data;
        axi.rlast  = last;
    endtask

    task automatic clear_beat();
        axi.rvalid = 1'b0;
        axi.rid    = 4'd0;
        axi.rdata  = 32'd0;
        axi.rlast  = 1'b0;
    endtask

    task automatic drain(input logic [3:0] id, input int n);
        for (int i = 0; i < n; i++) begin
            drive_beat(id, 32'hD0D0_0000 + i, 1'b1);
            step();
        end
        clear_beat();
    endtask

    // Bounded wait for arvalid, then completes the AR handshake.
    task automatic wait_ar(output bit found, output ar_t got);
        found = 1'b0;
        got   = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (axi.arvalid === 1'b1) begin
                got = {axi.araddr, axi.arid, axi.arlen};
                found = 1'b1;
                axi.arready = 1'b1;
                step();
                axi.arready = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        inst_rd_req = 1'b0; inst_rd_addr = 32'd0; inst_rd_type = 3'd0;
        data_rd_req = 1'b0; data_rd_addr = 32'd0; data_rd_type = 3'd0;
        axi.arready = 1'b0; axi.rresp = 2'b00;
        clear_beat();
        #3;
        n_checks++; if (axi.arvalid !== 1'b0) $display("FAIL rst_arvalid got=%b exp=0", axi.arvalid); else n_pass++;
        n_checks++; if (axi.araddr !== 32'd0) $display("FAIL rst_araddr got=%h exp=0", axi.araddr); else n_pass++;
        n_checks++; if (axi.arid !== 4'd0) $display("FAIL rst_arid got=%h exp=0", axi.arid); else n_pass++;
        n_checks++; if (axi.arlen !== 8'd0) $display("FAIL rst_arlen got=%h exp=0", axi.arlen); else n_pass++;
        n_checks++; if ({inst_rd_addr_ok, data_rd_addr_ok} !== 2'b00) $display("FAIL rst_addr_ok got=%b exp=00", {inst_rd_addr_ok, data_rd_addr_ok}); else n_pass++;
        n_checks++; if ({inst_rd_data_ok, data_rd_data_ok} !== 2'b00) $display("FAIL rst_data_ok got=%b exp=00", {inst_rd_data_ok, data_rd_data_ok}); else n_pass++;
        n_checks++; if (axi.rready !== 1'b1) $display("FAIL rst_rready got=%b exp=1", axi.rready); else n_pass++;
        step(); step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_dcache_line();
        bit  found;
        ar_t got, exp;
        data_rd_req = 1'b1; data_rd_addr = 32'h1C00_0040; data_rd_type = 3'b100;
        #1;
        n_checks++; if (data_rd_addr_ok !== 1'b1) $display("FAIL line_addr_ok got=%b exp=1", data_rd_addr_ok); else n_pass++;
        n_checks++; if (inst_rd_addr_ok !== 1'b0) $display("FAIL line_inst_addr_ok got=%b exp=0", inst_rd_addr_ok); else n_pass++;
        ar_q.push_back('{addr: 32'h1C00_0040, id: 4'd1, len: 8'd3});
        step();
        data_rd_req = 1'b0;
        n_checks++; if (axi.arvalid !== 1'b1) $display("FAIL line_arvalid got=%b exp=1", axi.arvalid); else n_pass++;
        wait_ar(found, got);
        n_checks++; if (!found) $display("FAIL line_ar_timeout got=none exp=ar"); else n_pass++;
        exp = ar_q.pop_front();
        n_checks++; if (got !== exp) $display("FAIL line_ar got=%h exp=%h", got, exp); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive_beat(4'd1, 32'hA5A5_0000 + 32'(i), (i == 3));
            r_q.push_back('{data: 32'hA5A5_0000 + 32'(i), last: (i == 3)});
            #1;
            if (data_rd_data_ok === 1'b1) begin
                beat_t eb;
                eb = r_q.pop_front();
                n_checks++; if ({data_rd_rdata, data_rd_last} !== eb) $display("FAIL line_beat%0d got=%h/%b exp=%h/%b", i, data_rd_rdata, data_rd_last, eb.data, eb.last); else n_pass++;
            end else begin
                n_checks++; $display("FAIL line_data_ok%0d got=%b exp=1", i, data_rd_data_ok);
            end
            n_checks++; if ({inst_rd_data_ok, inst_rd_rdata, inst_rd_last} !== 34'd0) $display("FAIL line_inst_mask%0d got=%b/%h/%b exp=0/0/0", i, inst_rd_data_ok, inst_rd_rdata, inst_rd_last); else n_pass++;
            step();
        end
        clear_beat();
    endtask

    task automatic test_simultaneous();
        bit  found;
        ar_t got, exp;
        inst_rd_req = 1'b1; inst_rd_addr = 32'h1C00_0000; inst_rd_type = 3'b000;
        data_rd_req = 1'b1; data_rd_addr = 32'h1C00_0100; data_rd_type = 3'b000;
        #1;
        n_checks++; if ({inst_rd_addr_ok, data_rd_addr_ok} !== 2'b01) $display("FAIL simul_first got=%b exp=01", {inst_rd_addr_ok, data_rd_addr_ok}); else n_pass++;
        ar_q.push_back('{addr: 32'h1C00_0100, id: 4'd1, len: 8'd0});
        step();
        data_rd_req = 1'b0;
        n_checks++; if (inst_rd_addr_ok !== 1'b0) $display("FAIL simul_send_block got=%b exp=0", inst_rd_addr_ok); else n_pass++;
        wait_ar(found, got);
        exp = ar_q.pop_front();
        n_checks++; if (!found || got !== exp) $display("FAIL simul_ar1 got=%h exp=%h", got, exp); else n_pass++;
        #1;
        n_checks++; if (inst_rd_addr_ok !== 1'b1) $display("FAIL simul_second got=%b exp=1", inst_rd_addr_ok); else n_pass++;
        ar_q.push_back('{addr: 32'h1C00_0000, id: 4'd0, len: 8'd0});
        step();
        inst_rd_req = 1'b0;
        wait_ar(found, got);
        exp = ar_q.pop_front();
        n_checks++; if (!found || got !== exp) $display("FAIL simul_ar2 got=%h exp=%h", got, exp); else n_pass++;
        drive_beat(4'd0, 32'h1111_2222, 1'b1);
        #1;
        n_checks++; if ({inst_rd_data_ok, data_rd_data_ok, inst_rd_rdata} !== {2'b10, 32'h1111_2222}) $display("FAIL simul_r_inst got=%b%b/%h exp=10/11112222", inst_rd_data_ok, data_rd_data_ok, inst_rd_rdata); else n_pass++;
        step();
        drive_beat(4'd1, 32'h3333_4444, 1'b1);
        #1;
        n_checks++; if ({inst_rd_data_ok, data_rd_data_ok, data_rd_rdata} !== {2'b01, 32'h3333_4444}) $display("FAIL simul_r_data got=%b%b/%h exp=01/33334444", inst_rd_data_ok, data_rd_data_ok, data_rd_rdata); else n_pass++;
        step();
        clear_beat();
    endtask

    task automatic test_starvation();
        ar_t exp, got;
        logic [3:0] wid;
        inst_rd_req = 1'b1; inst_rd_addr = 32'h1C00_0200; inst_rd_type = 3'b000;
        data_rd_req = 1'b1; data_rd_addr = 32'h1C00_0300; data_rd_type = 3'b000;
        for (int p = 0; p < 2; p++) begin
            for (int r = 1; r <= 9; r++) begin
                wid = (r == 9) ? 4'd0 : 4'd1;
                #1;
                n_checks++; if ({inst_rd_addr_ok, data_rd_addr_ok} !== ((r == 9) ? 2'b10 : 2'b01)) $display("FAIL starve_p%0d_r%0d got=%b exp=%b", p, r, {inst_rd_addr_ok, data_rd_addr_ok}, ((r == 9) ? 2'b10 : 2'b01)); else n_pass++;
                ar_q.push_back('{addr: (r == 9) ? 32'h1C00_0200 : 32'h1C00_0300, id: wid, len: 8'd0});
                step();
                got = {axi.araddr, axi.arid, axi.arlen};
                exp = ar_q.pop_front();
                n_checks++; if (axi.arvalid !== 1'b1 || got !== exp) $display("FAIL starve_ar_p%0d_r%0d got=%b/%h exp=1/%h", p, r, axi.arvalid, got, exp); else n_pass++;
                axi.arready = 1'b1;
                drive_beat(wid, 32'h5000_0000 + 32'(r), 1'b1);
                #1;
                n_checks++; if ({inst_rd_data_ok, data_rd_data_ok} !== ((r == 9) ? 2'b10 : 2'b01)) $display("FAIL starve_r_p%0d_r%0d got=%b exp=%b", p, r, {inst_rd_data_ok, data_rd_data_ok}, ((r == 9) ? 2'b10 : 2'b01)); else n_pass++;
                step();
                axi.arready = 1'b0;
                clear_beat();
            end
        end
        inst_rd_req = 1'b0;
        data_rd_req = 1'b0;
        step();
    endtask

    task automatic test_outstanding_cap();
        bit  found;
        ar_t got, exp;
        data_rd_type = 3'b000;
        for (int k = 0; k < 2; k++) begin
            data_rd_req = 1'b1; data_rd_addr = 32'h1C00_1000 + 32'(16 * k);
            #1;
            n_checks++; if (data_rd_addr_ok !== 1'b1) $display("FAIL cap_accept%0d got=%b exp=1", k, data_rd_addr_ok); else n_pass++;
            ar_q.push_back('{addr: 32'h1C00_1000 + 32'(16 * k), id: 4'd1, len: 8'd0});
            step();
            data_rd_req = 1'b0;
            wait_ar(found, got);
            exp = ar_q.pop_front();
            n_checks++; if (!found || got !== exp) $display("FAIL cap_ar%0d got=%h exp=%h", k, got, exp); else n_pass++;
        end
        data_rd_req = 1'b1; data_rd_addr = 32'h1C00_1020;
        #1;
        n_checks++; if (data_rd_addr_ok !== 1'b0) $display("FAIL cap_block got=%b exp=0", data_rd_addr_ok); else n_pass++;
        drive_beat(4'd5, 32'hBAD0_BAD0, 1'b1);
        #1;
        n_checks++; if ({inst_rd_data_ok, data_rd_data_ok} !== 2'b00) $display("FAIL cap_bad_rid got=%b exp=00", {inst_rd_data_ok, data_rd_data_ok}); else n_pass++;
        step();
        clear_beat();
        #1;
        n_checks++; if ({data_rd_addr_ok, axi.arvalid} !== 2'b00) $display("FAIL cap_after_bad got=%b exp=00", {data_rd_addr_ok, axi.arvalid}); else n_pass++;
        drive_beat(4'd1, 32'h0000_0001, 1'b1);
        #1;
        n_checks++; if (data_rd_addr_ok !== 1'b0) $display("FAIL cap_same_cycle got=%b exp=0", data_rd_addr_ok); else n_pass++;
        step();
        clear_beat();
        #1;
        n_checks++; if (data_rd_addr_ok !== 1'b1) $display("FAIL cap_release got=%b exp=1", data_rd_addr_ok); else n_pass++;
        ar_q.push_back('{addr: 32'h1C00_1020, id: 4'd1, len: 8'd0});
        step();
        data_rd_req = 1'b0;
        wait_ar(found, got);
        exp = ar_q.pop_front();
        n_checks++; if (!found || got !== exp) $display("FAIL cap_ar3 got=%h exp=%h", got, exp); else n_pass++;
        drain(4'd1, 2);
    endtask

    task automatic test_simul_incdec();
        bit  found;
        ar_t got, exp;
        drive_beat(4'd0, 32'h0, 1'b1);
        step();
        clear_beat();
        inst_rd_req = 1'b1; inst_rd_addr = 32'h1C00_2000; inst_rd_type = 3'b100;
        #1;
        n_checks++; if (inst_rd_addr_ok !== 1'b1) $display("FAIL incdec_first got=%b exp=1", inst_rd_addr_ok); else n_pass++;
        ar_q.push_back('{addr: 32'h1C00_2000, id: 4'd0, len: 8'd3});
        step();
        inst_rd_req = 1'b0;
        wait_ar(found, got);
        exp = ar_q.pop_front();
        n_checks++; if (!found || got !== exp) $display("FAIL incdec_ar1 got=%h exp=%h", got, exp); else n_pass++;
        inst_rd_req = 1'b1; inst_rd_addr = 32'h1C00_2010; inst_rd_type = 3'b000;
        drive_beat(4'd0, 32'h0, 1'b1);
        #1;
        n_checks++; if ({inst_rd_addr_ok, inst_rd_data_ok} !== 2'b11) $display("FAIL incdec_both got=%b exp=11", {inst_rd_addr_ok, inst_rd_data_ok}); else n_pass++;
        ar_q.push_back('{addr: 32'h1C00_2010, id: 4'd0, len: 8'd0});
        step();
        clear_beat();
        inst_rd_req = 1'b0;
        wait_ar(found, got);
        exp = ar_q.pop_front();
        n_checks++; if (!found || got !== exp) $display("FAIL incdec_ar2 got=%h exp=%h", got, exp); else n_pass++;
        inst_rd_req = 1'b1; inst_rd_addr = 32'h1C00_2020;
        #1;
        n_checks++; if (inst_rd_addr_ok !== 1'b1) $display("FAIL incdec_third got=%b exp=1", inst_rd_addr_ok); else n_pass++;
        ar_q.push_back('{addr: 32'h1C00_2020, id: 4'd0, len: 8'd0});
        step();
        inst_rd_req = 1'b0;
        wait_ar(found, got);
        exp = ar_q.pop_front();
        n_checks++; if (!found || got !== exp) $display("FAIL incdec_ar3 got=%h exp=%h", got, exp); else n_pass++;
        inst_rd_req = 1'b1;
        #1;
        n_checks++; if (inst_rd_addr_ok !== 1'b0) $display("FAIL incdec_cap got=%b exp=0", inst_rd_addr_ok); else n_pass++;
        inst_rd_req = 1'b0;
        drain(4'd0, 2);
    endtask

    task automatic test_reset_mid_send();
        bit  found;
        ar_t got, exp;
        data_rd_req = 1'b1; data_rd_addr = 32'h1C00_3000; data_rd_type = 3'b100;
        #1;
        n_checks++; if (data_rd_addr_ok !== 1'b1) $display("FAIL rstmid_accept got=%b exp=1", data_rd_addr_ok); else n_pass++;
        step();
        data_rd_req = 1'b0;
        n_checks++; if (axi.arvalid !== 1'b1) $display("FAIL rstmid_send got=%b exp=1", axi.arvalid); else n_pass++;
        #1;
        resetn = 1'b0;
        #1;
        n_checks++; if ({axi.arvalid, axi.araddr, axi.arlen} !== 41'd0) $display("FAIL rstmid_clear got=%b/%h/%h exp=0/0/0", axi.arvalid, axi.araddr, axi.arlen); else n_pass++;
        step(); step();
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            data_rd_req = 1'b1; data_rd_addr = 32'h1C00_3100 + 32'(16 * k); data_rd_type = 3'b000;
            #1;
            n_checks++; if (data_rd_addr_ok !== 1'b1) $display("FAIL rstmid_cnt%0d got=%b exp=1", k, data_rd_addr_ok); else n_pass++;
            ar_q.push_back('{addr: 32'h1C00_3100 + 32'(16 * k), id: 4'd1, len: 8'd0});
            step();
            data_rd_req = 1'b0;
            wait_ar(found, got);
            exp = ar_q.pop_front();
            n_checks++; if (!found || got !== exp) $display("FAIL rstmid_ar%0d got=%h exp=%h", k, got, exp); else n_pass++;
        end
        drain(4'd1, 2);
    endtask

    initial begin
        test_reset();
        test_dcache_line();
        test_simultaneous();
        test_starvation();
        test_outstanding_cap();
        test_simul_incdec();
        test_reset_mid_send();
        n_checks++; if (ar_q.size() + r_q.size() != 0) $display("FAIL scoreboard_left got=%0d exp=0", ar_q.size() + r_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
